// File: rtl/idma_axis_write_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXIS write manager port among NumInp backends.
// Optional performance counters are enabled with `define IDMA_AXIS_WRITE_ARB_PERF_EN.
module idma_axis_write_arbiter #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned StrbWidth = DataWidth / 8,
  parameter int unsigned CntWidth  = 32,
  parameter int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumInp-1:0]             inp_tvalid_i,
  output logic [NumInp-1:0]             inp_tready_o,
  input  logic [NumInp*DataWidth-1:0]   inp_tdata_i,
  input  logic [NumInp*StrbWidth-1:0]   inp_tkeep_i,
  input  logic [NumInp-1:0]             inp_tlast_i,
  output logic                          oup_tvalid_o,
  input  logic                          oup_tready_i,
  output logic [DataWidth-1:0]          oup_tdata_o,
  output logic [StrbWidth-1:0]          oup_tkeep_o,
  output logic                          oup_tlast_o,
  output logic [IdxWidth-1:0]           oup_tid_o,
  output logic                          busy_o,
  output logic [CntWidth-1:0]           beat_cnt_o,
  output logic [CntWidth-1:0]           pkt_cnt_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] rr_sel, sel, cand_idx;
  logic                any_valid, hs;
  int                  cand;

  logic [DataWidth-1:0] data_arr [NumInp];
  logic [StrbWidth-1:0] keep_arr [NumInp];

  for (genvar i = 0; i < NumInp; i++) begin : g_unpack
    assign data_arr[i] = inp_tdata_i[i*DataWidth +: DataWidth];
    assign keep_arr[i] = inp_tkeep_i[i*StrbWidth +: StrbWidth];
  end

  function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] idx);
    if (int'(idx) >= int'(NumInp) - 1) return '0;
    return idx + IdxWidth'(1);
  endfunction

  // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins.
  always_comb begin
    rr_sel    = rr_ptr_q;
    any_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = int'(NumInp) - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= int'(NumInp)) cand = cand - int'(NumInp);
      cand_idx = IdxWidth'(cand);
      if (inp_tvalid_i[cand_idx]) begin
        rr_sel    = cand_idx;
        any_valid = 1'b1;
      end
    end
  end

  // Handshake: a beat transfers when oup_tvalid_o and oup_tready_i are both high at a rising
  // clk edge; once tvalid is shown the selected source is held until that beat is accepted.
  always_comb begin
    sel = '0;
    if (!rst_i) sel = (state_q == LOCKED) ? lock_idx_q : rr_sel;
  end

  assign oup_tvalid_o = !rst_i && inp_tvalid_i[sel];
  assign oup_tdata_o  = data_arr[sel];
  assign oup_tkeep_o  = keep_arr[sel];
  assign oup_tlast_o  = inp_tlast_i[sel];
  assign oup_tid_o    = sel;
  assign inp_tready_o = rst_i ? '0 : (NumInp'(oup_tready_i) << sel);
  assign busy_o       = !rst_i && (state_q == LOCKED);
  assign hs           = oup_tvalid_o && oup_tready_i;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          if (hs && oup_tlast_o) begin
            rr_ptr_d = wrap_inc(sel);
          end else begin
            state_d    = LOCKED;
            lock_idx_d = sel;
          end
        end
      end
      LOCKED: begin
        if (hs && oup_tlast_o) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(lock_idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef IDMA_AXIS_WRITE_ARB_PERF_EN
  logic [CntWidth-1:0] beat_cnt_q, pkt_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (hs) begin
      beat_cnt_q <= beat_cnt_q + CntWidth'(1);
      if (oup_tlast_o) pkt_cnt_q <= pkt_cnt_q + CntWidth'(1);
    end
  end

  assign beat_cnt_o = beat_cnt_q;
  assign pkt_cnt_o  = pkt_cnt_q;
`else
  assign beat_cnt_o = '0;
  assign pkt_cnt_o  = '0;
`endif

endmodule
